driver_arbiter: RTL and testbench
=================================

DRIVER_ARBITER -- requirements
Module: driver_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters competing for the shared net.
REQ-002 Parameter WIDTH, default 8: width of each requester data word and of the shared net.
REQ-003 Parameter MAX_HOLD, default 16: maximum OWN cycles per grant when the timeout is compiled in.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port req, input, N_REQ: per-requester request to drive the net; held high for the whole transfer.
REQ-007 Port data_in, input, N_REQ*WIDTH: requester i drives bits [i*WIDTH +: WIDTH].
REQ-008 Port gnt, output, N_REQ: registered one-hot grant, all-zero when no owner.
REQ-009 Port out, output, WIDTH: registered shared net; the only driver of the resolved value.
REQ-010 Port out_valid, output, 1: registered; high when out carries owner data.
REQ-011 Port timeout, output, 1: one-cycle pulse on forced release; constant 0 without the macro.

Function
REQ-012 The block SHALL guarantee exactly one source for out: a registered mux of data_in selected by gnt, with no other assignment.
REQ-013 FSM states SHALL be IDLE, OWN, TURN.
REQ-014 IDLE: if any req bit is high, the block SHALL grant the first requesting index after last_owner (wrapping N_REQ-1 -> 0), set gnt at the next edge, and enter OWN; otherwise it stays in IDLE.
REQ-015 OWN: on each edge with req[owner]=1, out <= data_in[owner] and out_valid <= 1.
REQ-016 OWN: on an edge with req[owner]=0, the block SHALL clear gnt and out_valid, set out to 0, record last_owner=owner, and enter TURN.
REQ-017 TURN SHALL last exactly one cycle with gnt=0 and out_valid=0, then enter IDLE; requests seen during TURN are not granted until IDLE.
REQ-018 Latency: req[i] rising in IDLE at cycle t gives gnt[i] at t+1 and out_valid with data at t+2.
REQ-019 Simultaneous requests SHALL be resolved by the round-robin order alone; no requester waits more than N_REQ-1 grants.
REQ-020 Non-owner req changes during OWN SHALL NOT affect gnt, out or out_valid.
REQ-021 gnt SHALL never have more than one bit set; out SHALL equal 0 whenever out_valid=0.

Reset
REQ-022 On rst_n=0 at an edge: state=IDLE, gnt=0, out=0, out_valid=0, timeout=0, hold counter=0, last_owner=N_REQ-1 (so index 0 wins first).
REQ-023 Reset asserted mid-OWN SHALL drop the grant at that edge with no TURN cycle; arbitration restarts from index 0.

Configuration
REQ-024 Macro DRIVER_ARB_TIMEOUT_EN defined: a hold counter SHALL count OWN cycles; on the edge ending the MAX_HOLD-th OWN cycle with req[owner] still high, the block SHALL force the OWN->TURN exit (REQ-016), pulse timeout for one cycle, and advance last_owner.
REQ-025 Macro not defined: no counter is present, an owner holds the net indefinitely, and timeout is tied 0.

Structure
REQ-026 Package driver_arb_pkg SHALL hold the state typedef (IDLE/OWN/TURN) and default constants for N_REQ, WIDTH, MAX_HOLD.
REQ-027 One combinational sub-module rr_pick SHALL compute the next one-hot grant from req and last_owner.

Verification
REQ-028 Single request: reset, req=4'b0100, data_in[2]=8'hA5 at t -> gnt=4'b0100 at t+1, out=8'hA5 with out_valid=1 at t+2.
REQ-029 Round-robin: req=4'b1111 held, each owner drops req for one cycle after 3 OWN cycles -> grant order 0,1,2,3,0 with one TURN cycle of gnt=0 between owners.
REQ-030 Release: owner 1 drops req at t -> gnt=0, out_valid=0, out=0 at t+1, TURN at t+1, IDLE at t+2, new grant at t+3 if req pending.
REQ-031 Timeout (macro on, MAX_HOLD=16): req[0] held high -> forced release after 16 OWN cycles, timeout=1 for one cycle, next grant goes to index 1 if requesting, else back to 0.
REQ-032 Reset mid-OWN: rst_n=0 while owner 3 drives 8'h3C -> gnt=0, out=0, out_valid=0 at that edge; with req=4'b1001 after reset, index 0 wins.
REQ-033 Invariant checks on every cycle: $onehot0(gnt); out_valid implies gnt!=0; !out_valid implies out==0.

Source files
------------

// File: rtl/driver_arb_pkg.sv
// Shared types and defaults for the driver arbiter: FSM state encoding,
// parameter defaults and the round-robin index helper.
package driver_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_MAX_HOLD = 16;

  // Index reached by stepping 'off' places past 'last', wrapping at n.
  function automatic int unsigned rr_index(input int unsigned last,
                                           input int unsigned off,
                                           input int unsigned n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/driver_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after
// last_i (wrapping), returned as one-hot and as a binary index.
module rr_pick
  import driver_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // The last step (k == N_REQ) lands on last_i itself, so it wins only alone.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'(rr_index(32'(last_i), k, N_REQ));
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/driver_arbiter.sv
// Round-robin owner arbitration for a single registered shared net.
// Optional forced-release hold limit enabled by DRIVER_ARB_TIMEOUT_EN.
module driver_arbiter
  import driver_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic                   timeout
);

  localparam int unsigned     IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("driver_arbiter: MAX_HOLD must be at least 1");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             expire;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

`ifdef DRIVER_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;

  // hold_q counts completed OWN cycles of the current grant.
  assign expire = (state_q == OWN) && req[owner_q] &&
                  (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (state_q == OWN && req[owner_q] && !expire) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        out_d   = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!req[owner_q] || expire) begin
          gnt_d   = '0;
          out_d   = '0;
          valid_d = 1'b0;
          last_d  = owner_q;
          state_d = TURN;
        end else begin
          out_d   = data_in[32'(owner_q) * WIDTH +: WIDTH];
          valid_d = 1'b1;
        end
      end
      TURN: begin
        gnt_d   = '0;
        out_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        out_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= LAST_IDX;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_driver_arbiter.sv
// Directed self-checking bench for driver_arbiter (4 requesters, 8-bit data).
module tb_driver_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [7:0]  out;
  logic        out_valid;
  logic        timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        inv_en   = 1'b0;

  logic [7:0] lane [4] = '{8'h11, 8'h22, 8'hA5, 8'h3C};
  int unsigned rr_order [5] = '{0, 1, 2, 3, 0};

  driver_arbiter #(
    .N_REQ    (4),
    .WIDTH    (8),
    .MAX_HOLD (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (inv_en) begin
      check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv_valid_gnt", 32'(!out_valid || (gnt != 4'b0)), 32'd1);
      check("inv_zero_out", 32'(out_valid || (out == 8'h00)), 32'd1);
    end
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    data_in = {lane[3], lane[2], lane[1], lane[0]};
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    inv_en = 1'b1;
    rst_n  = 1'b1;
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single request on lane 2
    req = 4'b0100;
    tick();
    check("single_gnt_t1", 32'(gnt), 32'h4);
    check("single_valid_t1", 32'(out_valid), 32'h0);
    tick();
    check("single_out_t2", 32'(out), 32'hA5);
    check("single_valid_t2", 32'(out_valid), 32'h1);
    req = 4'b0000;
    tick();
    check("single_turn_gnt", 32'(gnt), 32'h0);
    check("single_turn_out", 32'(out), 32'h0);
    tick();
    check("single_idle_gnt", 32'(gnt), 32'h0);

    // Round robin from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(4'b0001 << rr_order[i]));
      if (i == 4) break;
      tick();
      check($sformatf("rr_out_%0d", i), 32'(out), 32'(lane[rr_order[i]]));
      check($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'h1);
      tick();
      req[rr_order[i]] = 1'b0;
      tick();
      check($sformatf("rr_turn_gnt_%0d", i), 32'(gnt), 32'h0);
      check($sformatf("rr_turn_valid_%0d", i), 32'(out_valid), 32'h0);
      req = 4'b1111;
      tick();
      check($sformatf("rr_idle_gnt_%0d", i), 32'(gnt), 32'h0);
      tick();
    end

    // Owner 0 releases; owner 1 then holds against non-owner churn
    req = 4'b0010;
    tick();
    check("rel0_turn_gnt", 32'(gnt), 32'h0);
    tick();
    tick();
    check("own1_gnt", 32'(gnt), 32'h2);
    tick();
    check("own1_out", 32'(out), 32'h22);
    req = 4'b1011;
    tick();
    check("nonowner_gnt", 32'(gnt), 32'h2);
    check("nonowner_out", 32'(out), 32'h22);
    check("nonowner_valid", 32'(out_valid), 32'h1);

    // Owner 1 drops at t
    req = 4'b1001;
    tick();
    check("rel1_t1_gnt", 32'(gnt), 32'h0);
    check("rel1_t1_valid", 32'(out_valid), 32'h0);
    check("rel1_t1_out", 32'(out), 32'h0);
    tick();
    check("rel1_t2_gnt", 32'(gnt), 32'h0);
    tick();
    check("rel1_t3_gnt", 32'(gnt), 32'h8);
    tick();
    check("own3_out", 32'(out), 32'h3C);
    check("own3_valid", 32'(out_valid), 32'h1);

    // Reset while owner 3 drives the net
    rst_n = 1'b0;
    tick();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    check("postrst_gnt", 32'(gnt), 32'h1);

    // Owner 0 holds: forced release with the timeout, indefinite hold without
    req = 4'b0011;
`ifdef DRIVER_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h1);
      check("hold_timeout", 32'(timeout), 32'h0);
    end
    tick();
    check("to_gnt", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_valid", 32'(out_valid), 32'h0);
    tick();
    check("to_pulse_end", 32'(timeout), 32'h0);
    check("to_idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("to_next_gnt", 32'(gnt), 32'h2);
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("to_back0_gnt", 32'(gnt), 32'h1);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h1);
      check("hold_timeout", 32'(timeout), 32'h0);
    end
    check("hold_out", 32'(out), 32'h11);
    check("hold_valid", 32'(out_valid), 32'h1);
`endif

    req = 4'b0000;
    tick();
    tick();
    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
